task_out_packer: RTL and testbench

//   Output stage of a task core. Collects variable-length result packets of IN_WIDTH-bit words,

---
 rtl/task_out_packer.sv | 148 ++++++++++++++
 tb/tb_task_out_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/task_out_packer.sv
// Result-packet output stage: buffers IN_WIDTH-bit words of a packet, then streams them
// to the manager as OUT_WIDTH-bit beats, most-significant slice first.
module task_out_packer #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int MAX_WORDS  = 81,
    parameter int SIZE_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [IN_WIDTH-1:0]   i_data,
    input  logic                  i_data_valid,
    input  logic                  i_input_last,
    output logic                  o_in_ready,
    input  logic                  i_tmanager_ready,
    output logic                  o_tanswer_ready,
    output logic [OUT_WIDTH-1:0]  o_tdata,
    output logic                  o_tanswer_data_last,
    output logic [SIZE_WIDTH-1:0] o_packet_size_in_bytes,
    output logic                  o_busy,
    output logic                  o_full,
    output logic                  o_overflow
);
    localparam int R   = IN_WIDTH / OUT_WIDTH;
    localparam int BW  = (R > 1) ? $clog2(R) : 1;
    localparam int AW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int CW  = $clog2(MAX_WORDS + 1);
    localparam int BPW = IN_WIDTH / 8;

    typedef enum logic [1:0] {s_LOAD, s_START, s_SEND} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic                  busy_q, busy_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;

    logic [IN_WIDTH-1:0]   mem [MAX_WORDS];
    logic [IN_WIDTH-1:0]   rdata_q;
    logic [AW-1:0]         raddr;
    logic                  wr_en;
    logic                  word_done;
    logic                  last_beat;
    logic [OUT_WIDTH-1:0]  slice;

    assign o_in_ready             = (state_q == s_LOAD);
    assign o_tanswer_ready        = (state_q == s_SEND);
    assign o_tanswer_data_last    = (state_q == s_SEND) && last_beat;
    assign o_tdata                = (state_q == s_SEND) ? slice : '0;
    assign o_packet_size_in_bytes = size_q;
    assign o_busy                 = busy_q;
    assign o_full                 = full_q;
    assign o_overflow             = ovf_q;

    assign word_done = (beat_q == BW'(R - 1));
    assign last_beat = word_done && (rd_cnt_q == wr_cnt_q - CW'(1));

    always_comb begin
        slice = '0;
        for (int b = 0; b < R; b++) begin
            if (beat_q == BW'(b)) slice = rdata_q[(R-1-b)*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        beat_d   = beat_q;
        size_d   = size_q;
        busy_d   = busy_q;
        full_d   = full_q;
        ovf_d    = ovf_q | (i_data_valid & ~o_in_ready);
        wr_en    = 1'b0;
        raddr    = rd_cnt_q[AW-1:0];
        case (state_q)
            s_LOAD: begin
                if (i_data_valid) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == CW'(MAX_WORDS - 1)) begin
                        full_d  = 1'b1;
                        state_d = s_START;
                    end else if (i_input_last) begin
                        state_d = s_START;
                    end
                end
            end
            s_START: begin
                size_d   = SIZE_WIDTH'(wr_cnt_q * BPW);
                busy_d   = 1'b1;
                rd_cnt_d = '0;
                beat_d   = '0;
                raddr    = '0;
                state_d  = s_SEND;
            end
            s_SEND: begin
                if (i_tmanager_ready) begin
                    if (last_beat) begin
                        state_d  = s_LOAD;
                        busy_d   = 1'b0;
                        size_d   = '0;
                        wr_cnt_d = '0;
                        full_d   = 1'b0;
                    end else if (word_done) begin
                        // Advance the read address on the same edge so the next word lands with no bubble.
                        beat_d   = '0;
                        rd_cnt_d = rd_cnt_q + CW'(1);
                        raddr    = rd_cnt_d[AW-1:0];
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = s_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= s_LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            beat_q   <= '0;
            size_q   <= '0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            beat_q   <= beat_d;
            size_q   <= size_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_cnt_q[AW-1:0]] <= i_data;
        rdata_q <= mem[raddr];
    end
endmodule

// File: tb/tb_task_out_packer.sv
// Directed bench for task_out_packer: a cycle table for the basic packet plus hand-written
// sequences for backpressure, full buffer, overflow, mid-packet reset and back-to-back packets.
module tb_task_out_packer;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_data_valid = 1'b0;
    logic        i_input_last = 1'b0;
    logic        o_in_ready;
    logic        i_tmanager_ready = 1'b0;
    logic        o_tanswer_ready;
    logic [7:0]  o_tdata;
    logic        o_tanswer_data_last;
    logic [11:0] o_packet_size_in_bytes;
    logic        o_busy;
    logic        o_full;
    logic        o_overflow;

    task_out_packer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MAX_WORDS(81), .SIZE_WIDTH(12)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_data_valid(i_data_valid),
        .i_input_last(i_input_last), .o_in_ready(o_in_ready), .i_tmanager_ready(i_tmanager_ready),
        .o_tanswer_ready(o_tanswer_ready), .o_tdata(o_tdata), .o_tanswer_data_last(o_tanswer_data_last),
        .o_packet_size_in_bytes(o_packet_size_in_bytes), .o_busy(o_busy), .o_full(o_full),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        last;
        logic        tready;
        logic        e_in_ready;
        logic        e_tvalid;
        logic [7:0]  e_tdata;
        logic        e_tlast;
        logic        e_busy;
        logic [11:0] e_size;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  cap[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  pk1 [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                              8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic [7:0]  pk_dead [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0]  pk_a [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0]  pk_b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        i_data = d; i_data_valid = 1'b1; i_input_last = l;
        step();
        i_data_valid = 1'b0; i_input_last = 1'b0;
    endtask

    task automatic send_pk1();
        send_word(32'h11223344, 1'b0);
        send_word(32'h55667788, 1'b0);
        send_word(32'h99AABBCC, 1'b1);
    endtask

    task automatic add_row(input logic [31:0] d, input logic v, input logic l,
                           input logic ir, input logic tv, input logic [7:0] td,
                           input logic tl, input logic b, input logic [11:0] sz);
        vec_t r;
        r.data = d; r.valid = v; r.last = l; r.tready = 1'b1;
        r.e_in_ready = ir; r.e_tvalid = tv; r.e_tdata = td; r.e_tlast = tl;
        r.e_busy = b; r.e_size = sz;
        tbl.push_back(r);
    endtask

    // Drains one packet; checks beat count, single last flag on the final beat, and hold stability.
    task automatic collect(input int n, input bit toggle, input bit junk, input string nm);
        int   got = 0;
        int   cyc = 0;
        int   nlast = 0;
        int   lastpos = -1;
        bit   phase = 1'b1;
        bit   holding = 1'b0;
        logic [7:0] held = '0;
        cap.delete();
        while (got < n && cyc < 2000) begin
            if (holding) chk({nm, " hold stable"}, {24'h0, o_tdata}, {24'h0, held});
            holding = 1'b0;
            i_tmanager_ready = toggle ? phase : 1'b1;
            phase = ~phase;
            i_data_valid = junk & o_tanswer_ready;
            i_data = 32'hFFFF_FFFF;
            if (o_tanswer_ready && i_tmanager_ready) begin
                cap.push_back(o_tdata);
                if (o_tanswer_data_last) begin nlast++; lastpos = got; end
                got++;
            end else if (o_tanswer_ready) begin
                holding = 1'b1;
                held = o_tdata;
            end
            step();
            cyc++;
        end
        i_data_valid = 1'b0;
        i_tmanager_ready = 1'b0;
        chk({nm, " beat count"}, got, n);
        chk({nm, " last count"}, nlast, 1);
        chk({nm, " last position"}, lastpos, n - 1);
        chk({nm, " idle tvalid"}, {31'h0, o_tanswer_ready}, 0);
        chk({nm, " idle busy"}, {31'h0, o_busy}, 0);
        chk({nm, " idle size"}, {20'h0, o_packet_size_in_bytes}, 0);
        chk({nm, " idle in_ready"}, {31'h0, o_in_ready}, 1);
    endtask

    initial begin
        // Test 1 as a cycle table: 3 words, then 12 beats with ready held high.
        add_row(32'h11223344, 1, 0, 1, 0, 8'h00, 0, 0, 12'd0);
        add_row(32'h55667788, 1, 0, 1, 0, 8'h00, 0, 0, 12'd0);
        add_row(32'h99AABBCC, 1, 1, 0, 0, 8'h00, 0, 0, 12'd0);
        for (int k = 0; k < 12; k++)
            add_row(32'h0, 0, 0, 0, 1, pk1[k], (k == 11), 1, 12'd12);
        add_row(32'h0, 0, 0, 1, 0, 8'h00, 0, 0, 12'd0);

        i_rst_n = 1'b0;
        step();
        chk("reset in_ready", {31'h0, o_in_ready}, 1);
        chk("reset tvalid", {31'h0, o_tanswer_ready}, 0);
        chk("reset tdata", {24'h0, o_tdata}, 0);
        chk("reset tlast", {31'h0, o_tanswer_data_last}, 0);
        chk("reset size", {20'h0, o_packet_size_in_bytes}, 0);
        chk("reset busy", {31'h0, o_busy}, 0);
        chk("reset full", {31'h0, o_full}, 0);
        chk("reset overflow", {31'h0, o_overflow}, 0);
        i_rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            i_data = tbl[i].data; i_data_valid = tbl[i].valid;
            i_input_last = tbl[i].last; i_tmanager_ready = tbl[i].tready;
            step();
            chk($sformatf("t1 row%0d in_ready", i), {31'h0, o_in_ready}, {31'h0, tbl[i].e_in_ready});
            chk($sformatf("t1 row%0d tvalid", i), {31'h0, o_tanswer_ready}, {31'h0, tbl[i].e_tvalid});
            chk($sformatf("t1 row%0d tdata", i), {24'h0, o_tdata}, {24'h0, tbl[i].e_tdata});
            chk($sformatf("t1 row%0d tlast", i), {31'h0, o_tanswer_data_last}, {31'h0, tbl[i].e_tlast});
            chk($sformatf("t1 row%0d busy", i), {31'h0, o_busy}, {31'h0, tbl[i].e_busy});
            chk($sformatf("t1 row%0d size", i), {20'h0, o_packet_size_in_bytes}, {20'h0, tbl[i].e_size});
        end
        i_data_valid = 1'b0; i_input_last = 1'b0; i_tmanager_ready = 1'b0;

        // Test 2: same packet under toggling backpressure.
        send_pk1();
        collect(12, 1'b1, 1'b0, "t2");
        foreach (pk1[k]) chk($sformatf("t2 beat%0d", k), {24'h0, cap[k]}, {24'h0, pk1[k]});

        // Test 3: 81 words without last; byte j of the stream carries value j mod 256.
        for (int w = 0; w < 81; w++) begin
            if (w == 80) chk("t3 full before word 81", {31'h0, o_full}, 0);
            send_word({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)}, 1'b0);
        end
        chk("t3 full", {31'h0, o_full}, 1);
        chk("t3 in_ready after 81", {31'h0, o_in_ready}, 0);
        step();
        chk("t3 busy", {31'h0, o_busy}, 1);
        chk("t3 size", {20'h0, o_packet_size_in_bytes}, 324);
        chk("t3 full in send", {31'h0, o_full}, 1);
        collect(324, 1'b0, 1'b0, "t3");
        for (int j = 0; j < 324; j++) chk($sformatf("t3 beat%0d", j), {24'h0, cap[j]}, j & 32'hFF);
        chk("t3 full cleared", {31'h0, o_full}, 0);

        // Test 4: words offered during SEND are dropped and flag sticky overflow.
        chk("t4 overflow before", {31'h0, o_overflow}, 0);
        send_pk1();
        collect(12, 1'b0, 1'b1, "t4");
        foreach (pk1[k]) chk($sformatf("t4 beat%0d", k), {24'h0, cap[k]}, {24'h0, pk1[k]});
        chk("t4 overflow set", {31'h0, o_overflow}, 1);
        send_word(32'h0A0B0C0D, 1'b1);
        collect(4, 1'b0, 1'b0, "t4b");
        chk("t4b beat0", {24'h0, cap[0]}, 32'h0A);
        chk("t4b beat3", {24'h0, cap[3]}, 32'h0D);
        chk("t4 overflow sticky", {31'h0, o_overflow}, 1);

        // Test 5: reset while beat 5 of 12 is presented.
        send_pk1();
        step();
        i_tmanager_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t5 beat5 before reset", {24'h0, o_tdata}, 32'h55);
        i_tmanager_ready = 1'b0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        chk("t5 tvalid", {31'h0, o_tanswer_ready}, 0);
        chk("t5 tlast", {31'h0, o_tanswer_data_last}, 0);
        chk("t5 busy", {31'h0, o_busy}, 0);
        chk("t5 size", {20'h0, o_packet_size_in_bytes}, 0);
        chk("t5 in_ready", {31'h0, o_in_ready}, 1);
        chk("t5 overflow cleared", {31'h0, o_overflow}, 0);
        i_tmanager_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t5 quiet%0d", k), {31'h0, o_tanswer_ready}, 0);
        end
        i_tmanager_ready = 1'b0;
        send_word(32'hDEADBEEF, 1'b1);
        collect(4, 1'b0, 1'b0, "t5");
        foreach (pk_dead[k]) chk($sformatf("t5 beat%0d", k), {24'h0, cap[k]}, {24'h0, pk_dead[k]});

        // Test 6: single-word packet, next packet held on the input the whole time.
        send_word(32'hA1B2C3D4, 1'b1);
        i_data = 32'h01020304; i_data_valid = 1'b1; i_input_last = 1'b1; i_tmanager_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t6 a beat%0d", k), {24'h0, o_tdata}, {24'h0, pk_a[k]});
            chk($sformatf("t6 a tlast%0d", k), {31'h0, o_tanswer_data_last}, (k == 3) ? 1 : 0);
            chk($sformatf("t6 in_ready%0d", k), {31'h0, o_in_ready}, 0);
        end
        step();
        chk("t6 in_ready rises", {31'h0, o_in_ready}, 1);
        chk("t6 tvalid low", {31'h0, o_tanswer_ready}, 0);
        step();
        i_data_valid = 1'b0; i_input_last = 1'b0; i_tmanager_ready = 1'b0;
        chk("t6 second accepted", {31'h0, o_in_ready}, 0);
        collect(4, 1'b0, 1'b0, "t6b");
        foreach (pk_b[k]) chk($sformatf("t6b beat%0d", k), {24'h0, cap[k]}, {24'h0, pk_b[k]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
